// File: rtl/paddle_pkg.sv
// Shared types and constants for the paddle frame tracker: raster defaults, mask codes,
// FSM states and the per-colour result record.
package paddle_pkg;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int MIN_PIXELS_DEF = 64;
  localparam int CNT_WIDTH_DEF  = 19;

  localparam logic [1:0] COL_NONE = 2'b00;
  localparam logic [1:0] COL_1    = 2'b01;
  localparam logic [1:0] COL_2    = 2'b10;
  localparam logic [1:0] COL_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PUBLISH
  } state_t;

  typedef struct packed {
    logic                     found;
    logic [CNT_WIDTH_DEF-1:0] cnt;
    logic [11:0]              x;
    logic [10:0]              y;
  } paddle_result_t;

  // Midpoints use one extra bit for the sum so edge-of-frame boxes cannot wrap.
  function automatic logic [11:0] mid_col(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[12:1];
  endfunction

  function automatic logic [10:0] mid_row(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[11:1];
  endfunction

endpackage

// File: rtl/paddle_frame_tracker_if.sv
// Result-record handshake between the frame tracker (master) and the game/overlay logic.
interface paddle_frame_tracker_if;
  import paddle_pkg::*;

  logic                     res_valid;
  logic                     res_ready;
  logic [1:0]               res_found;
  logic [CNT_WIDTH_DEF-1:0] res_cnt1;
  logic [CNT_WIDTH_DEF-1:0] res_cnt2;
  logic [11:0]              res_x1;
  logic [11:0]              res_x2;
  logic [10:0]              res_y1;
  logic [10:0]              res_y2;

  modport master (
    output res_valid, res_found, res_cnt1, res_cnt2, res_x1, res_x2, res_y1, res_y2,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_found, res_cnt1, res_cnt2, res_x1, res_x2, res_y1, res_y2,
    output res_ready
  );

endinterface

// File: rtl/paddle_bbox_accum.sv
// Per-colour mask pixel counter and bounding-box tracker; cleared at each frame start.
module paddle_bbox_accum
  import paddle_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic [10:0]          row,
  input  logic [11:0]          col,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic [11:0]          xmin,
  output logic [11:0]          xmax,
  output logic [10:0]          ymin,
  output logic [10:0]          ymax
);

  localparam logic [11:0] X_INIT = 12'(H_ACTIVE - 1);
  localparam logic [10:0] Y_INIT = 11'(V_ACTIVE - 1);

  // Minima start at the far edge so the first hit always replaces them.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      xmin <= X_INIT;
      xmax <= '0;
      ymin <= Y_INIT;
      ymax <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_WIDTH'(1);
      if (col < xmin) xmin <= col;
      if (col > xmax) xmax <= col;
      if (row < ymin) ymin <= row;
      if (row > ymax) ymax <= row;
    end
  end

endmodule

// File: rtl/paddle_frame_tracker.sv
// Frame sequencer: raster position, per-frame mask gating, dual-colour accumulation and
// end-of-frame result publish. Optional ROI window enabled by defining PADDLE_ROI_EN.
module paddle_frame_tracker
  import paddle_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int MIN_PIXELS = MIN_PIXELS_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [1:0]  color_code,
  input  logic        code_valid,
`ifdef PADDLE_ROI_EN
  input  logic [11:0] roi_x0,
  input  logic [11:0] roi_x1,
  input  logic [10:0] roi_y0,
  input  logic [10:0] roi_y1,
`endif
  output logic [10:0] row,
  output logic [11:0] col,
  output logic        overrun,
  paddle_frame_tracker_if.master res
);

  localparam logic [10:0] ROW_LAST = 11'(V_ACTIVE - 1);
  localparam logic [11:0] COL_LAST = 12'(H_ACTIVE - 1);

  state_t         state_q, state_d;
  logic [10:0]    row_q;
  logic [11:0]    col_q;
  logic           overrun_q;
  logic           clear, scan_pix, last_pix, handshake, roi_hit, hit1, hit2;
  logic [CNT_WIDTH-1:0] cnt1, cnt2;
  logic [11:0]    xmin1, xmax1, xmin2, xmax2;
  logic [10:0]    ymin1, ymax1, ymin2, ymax2;
  paddle_result_t r1, r2;

  // A frame_start on a pixel cycle wins: that pixel belongs to no frame.
  assign scan_pix  = (state_q == ST_SCAN) && pix_valid && !frame_start;
  assign last_pix  = scan_pix && (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign handshake = (state_q == ST_PUBLISH) && res.res_ready;

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_SCAN;
          clear   = 1'b1;
        end
      end
      ST_SCAN: begin
        if (frame_start) begin
          clear = 1'b1;
        end else if (last_pix) begin
          state_d = ST_PUBLISH;
        end
      end
      ST_PUBLISH: begin
        if (handshake) begin
          if (frame_start) begin
            state_d = ST_SCAN;
            clear   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // The last pixel wraps both counters, so row/col rest at 0 outside SCAN.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row_q <= '0;
      col_q <= '0;
    end else if (scan_pix) begin
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? 11'd0 : row_q + 11'd1;
      end else begin
        col_q <= col_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if ((state_q == ST_PUBLISH) && frame_start && !res.res_ready) begin
      overrun_q <= 1'b1;
    end
  end

`ifdef PADDLE_ROI_EN
  logic [11:0] roi_x0_q, roi_x1_q;
  logic [10:0] roi_y0_q, roi_y1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      roi_x0_q <= '0;
      roi_x1_q <= '0;
      roi_y0_q <= '0;
      roi_y1_q <= '0;
    end else if (clear) begin
      roi_x0_q <= roi_x0;
      roi_x1_q <= roi_x1;
      roi_y0_q <= roi_y0;
      roi_y1_q <= roi_y1;
    end
  end

  assign roi_hit = (col_q >= roi_x0_q) && (col_q <= roi_x1_q) &&
                   (row_q >= roi_y0_q) && (row_q <= roi_y1_q);
`else
  assign roi_hit = 1'b1;
`endif

  assign hit1 = scan_pix && code_valid && roi_hit &&
                ((color_code == COL_1) || (color_code == COL_BOTH));
  assign hit2 = scan_pix && code_valid && roi_hit &&
                ((color_code == COL_2) || (color_code == COL_BOTH));

  paddle_bbox_accum #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_accum1 (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .en   (hit1),
    .row  (row_q),
    .col  (col_q),
    .cnt  (cnt1),
    .xmin (xmin1),
    .xmax (xmax1),
    .ymin (ymin1),
    .ymax (ymax1)
  );

  paddle_bbox_accum #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_accum2 (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .en   (hit2),
    .row  (row_q),
    .col  (col_q),
    .cnt  (cnt2),
    .xmin (xmin2),
    .xmax (xmax2),
    .ymin (ymin2),
    .ymax (ymax2)
  );

  // Accumulators are frozen in PUBLISH, so the record is stable until the handshake.
  always_comb begin
    r1       = '0;
    r1.cnt   = CNT_WIDTH_DEF'(cnt1);
    r1.found = (cnt1 >= CNT_WIDTH'(MIN_PIXELS));
    if (r1.found) begin
      r1.x = mid_col(xmin1, xmax1);
      r1.y = mid_row(ymin1, ymax1);
    end
    r2       = '0;
    r2.cnt   = CNT_WIDTH_DEF'(cnt2);
    r2.found = (cnt2 >= CNT_WIDTH'(MIN_PIXELS));
    if (r2.found) begin
      r2.x = mid_col(xmin2, xmax2);
      r2.y = mid_row(ymin2, ymax2);
    end
  end

  assign res.res_valid = (state_q == ST_PUBLISH);
  assign res.res_found = {r2.found, r1.found};
  assign res.res_cnt1  = r1.cnt;
  assign res.res_cnt2  = r2.cnt;
  assign res.res_x1    = r1.x;
  assign res.res_x2    = r2.x;
  assign res.res_y1    = r1.y;
  assign res.res_y2    = r2.y;

  assign row     = row_q;
  assign col     = col_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_paddle_frame_tracker.sv
// Scoreboard bench for paddle_frame_tracker on a reduced 16x12 raster.
module tb_paddle_frame_tracker;
  import paddle_pkg::*;

  localparam int H    = 16;
  localparam int V    = 12;
  localparam int MINP = 64;

  typedef struct {
    logic [1:0] found;
    int cnt1, cnt2, x1, x2, y1, y2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, frame_start, pix_valid, code_valid;
  logic [1:0]  color_code;
  logic [10:0] row;
  logic [11:0] col;
  logic        overrun;

  exp_t       sb[$];
  logic [1:0] img [V][H];
  int         n_cmp = 0;
  int         n_bad = 0;

  paddle_frame_tracker_if res_if();

  paddle_frame_tracker #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .MIN_PIXELS(MINP),
    .CNT_WIDTH (CNT_WIDTH_DEF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .color_code (color_code),
    .code_valid (code_valid),
    .row        (row),
    .col        (col),
    .overrun    (overrun),
    .res        (res_if)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clearImage();
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        img[r][c] = COL_NONE;
  endtask

  task automatic fillBlock(input int r0, input int c0, input int h, input int w, input logic [1:0] code);
    for (int r = r0; r < r0 + h; r++)
      for (int c = c0; c < c0 + w; c++)
        img[r][c] = code;
  endtask

  // Drives n_pix pixels of img with random gaps; a full frame pushes its expected record.
  task automatic applyStimulus(input bit send_start, input int n_pix);
    int  cnt[2], xmn[2], xmx[2], ymn[2], ymx[2];
    int  r, c;
    bit  cv, full;
    exp_t e;
    full = (n_pix == H * V);
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; xmn[k] = H - 1; xmx[k] = 0; ymn[k] = V - 1; ymx[k] = 0;
    end
    if (send_start) begin
      @(negedge clk);
      frame_start = 1'b1; pix_valid = 1'b0; code_valid = 1'b0;
      @(negedge clk);
      frame_start = 1'b0;
    end
    for (int idx = 0; idx < n_pix; idx++) begin
      r = idx / H;
      c = idx % H;
      if ($urandom_range(0, 7) == 0) begin
        pix_valid  = 1'b0;
        code_valid = 1'($urandom_range(0, 1));
        color_code = 2'($urandom_range(1, 3));
        @(negedge clk);
      end
      if (idx == 20) begin
        checkOutput("row_pos", 32'(row), 32'd1);
        checkOutput("col_pos", 32'(col), 32'd4);
      end
      if (full && idx == n_pix - 1) checkOutput("pre_valid", 32'(res_if.res_valid), 32'd0);
      cv = !((img[r][c] == COL_NONE) && ($urandom_range(0, 3) == 0));
      pix_valid  = 1'b1;
      code_valid = cv;
      color_code = cv ? img[r][c] : 2'($urandom_range(1, 3));
      if (cv) begin
        for (int k = 0; k < 2; k++) begin
          if (img[r][c][k]) begin
            cnt[k]++;
            if (c < xmn[k]) xmn[k] = c;
            if (c > xmx[k]) xmx[k] = c;
            if (r < ymn[k]) ymn[k] = r;
            if (r > ymx[k]) ymx[k] = r;
          end
        end
      end
      @(negedge clk);
    end
    pix_valid  = 1'b0;
    code_valid = 1'b0;
    color_code = COL_NONE;
    if (full) begin
      checkOutput("latency_valid", 32'(res_if.res_valid), 32'd1);
      e.found[0] = (cnt[0] >= MINP);
      e.found[1] = (cnt[1] >= MINP);
      e.cnt1 = cnt[0];
      e.cnt2 = cnt[1];
      e.x1 = e.found[0] ? (xmn[0] + xmx[0]) / 2 : 0;
      e.y1 = e.found[0] ? (ymn[0] + ymx[0]) / 2 : 0;
      e.x2 = e.found[1] ? (xmn[1] + xmx[1]) / 2 : 0;
      e.y2 = e.found[1] ? (ymn[1] + ymx[1]) / 2 : 0;
      sb.push_back(e);
    end
  endtask

  task automatic compareRecord(input exp_t e);
    checkOutput("res_found", 32'(res_if.res_found), 32'(e.found));
    checkOutput("res_cnt1",  32'(res_if.res_cnt1),  32'(e.cnt1));
    checkOutput("res_cnt2",  32'(res_if.res_cnt2),  32'(e.cnt2));
    checkOutput("res_x1",    32'(res_if.res_x1),    32'(e.x1));
    checkOutput("res_y1",    32'(res_if.res_y1),    32'(e.y1));
    checkOutput("res_x2",    32'(res_if.res_x2),    32'(e.x2));
    checkOutput("res_y2",    32'(res_if.res_y2),    32'(e.y2));
  endtask

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (res_if.res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) checkOutput("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic collectResult(input int hold);
    bit   ok;
    exp_t e;
    waitValid(ok);
    if (!ok) return;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    compareRecord(e);
    repeat (hold) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(res_if.res_valid), 32'd1);
      checkOutput("hold_cnt1", 32'(res_if.res_cnt1), 32'(e.cnt1));
    end
    res_if.res_ready = 1'b1;
    @(negedge clk);
    res_if.res_ready = 1'b0;
    checkOutput("ack_drop", 32'(res_if.res_valid), 32'd0);
  endtask

  initial begin
    bit   ok;
    exp_t e;
    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; code_valid = 1'b0;
    color_code = COL_NONE; res_if.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_valid",   32'(res_if.res_valid), 32'd0);
    checkOutput("rst_found",   32'(res_if.res_found), 32'd0);
    checkOutput("rst_cnt1",    32'(res_if.res_cnt1),  32'd0);
    checkOutput("rst_cnt2",    32'(res_if.res_cnt2),  32'd0);
    checkOutput("rst_x1",      32'(res_if.res_x1),    32'd0);
    checkOutput("rst_overrun", 32'(overrun),          32'd0);
    checkOutput("rst_row",     32'(row),              32'd0);
    checkOutput("rst_col",     32'(col),              32'd0);

    $display("[TB] 8x8 colour1 block plus 4x4 colour2 block");
    clearImage();
    fillBlock(2, 4, 8, 8, COL_1);
    fillBlock(0, 12, 4, 4, COL_2);
    applyStimulus(1'b1, H * V);
    collectResult(2);

    $display("[TB] code 11 at first and last pixel only");
    clearImage();
    img[0][0]         = COL_BOTH;
    img[V-1][H-1]     = COL_BOTH;
    applyStimulus(1'b1, H * V);
    collectResult(0);

    $display("[TB] handshake and frame_start in the same cycle");
    clearImage();
    fillBlock(3, 0, 8, 8, COL_2);
    applyStimulus(1'b1, H * V);
    waitValid(ok);
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      compareRecord(e);
      res_if.res_ready = 1'b1;
      frame_start = 1'b1;
      @(negedge clk);
      res_if.res_ready = 1'b0;
      frame_start = 1'b0;
      checkOutput("simul_ack", 32'(res_if.res_valid), 32'd0);
      clearImage();
      fillBlock(0, 0, 8, 8, COL_BOTH);
      applyStimulus(1'b0, H * V);
      collectResult(0);
      checkOutput("simul_no_overrun", 32'(overrun), 32'd0);
    end

    $display("[TB] short frame restarted mid-scan");
    clearImage();
    fillBlock(0, 0, V, H, COL_1);
    applyStimulus(1'b1, 5 * H + 3);
    checkOutput("short_no_valid", 32'(res_if.res_valid), 32'd0);
    clearImage();
    fillBlock(4, 8, 8, 8, COL_1);
    applyStimulus(1'b1, H * V);
    collectResult(0);

    $display("[TB] frame dropped while record pending");
    clearImage();
    fillBlock(0, 8, 8, 8, COL_2);
    fillBlock(9, 0, 3, 5, COL_1);
    applyStimulus(1'b1, H * V);
    waitValid(ok);
    if (ok && sb.size() > 0) begin
      e = sb[0];
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      pix_valid = 1'b1; code_valid = 1'b1; color_code = COL_BOTH;
      repeat (10) @(negedge clk);
      pix_valid = 1'b0; code_valid = 1'b0; color_code = COL_NONE;
      checkOutput("ovr_flag",  32'(overrun),          32'd1);
      checkOutput("ovr_valid", 32'(res_if.res_valid), 32'd1);
      checkOutput("ovr_row",   32'(row),              32'd0);
      checkOutput("ovr_col",   32'(col),              32'd0);
      compareRecord(e);
      collectResult(0);
      checkOutput("ovr_sticky", 32'(overrun), 32'd1);
    end

    $display("[TB] reset during publish");
    clearImage();
    fillBlock(1, 1, 10, 10, COL_1);
    applyStimulus(1'b1, H * V);
    waitValid(ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (sb.size() > 0) e = sb.pop_front();
    checkOutput("prst_valid",   32'(res_if.res_valid), 32'd0);
    checkOutput("prst_overrun", 32'(overrun),          32'd0);
    checkOutput("prst_cnt1",    32'(res_if.res_cnt1),  32'd0);
    checkOutput("prst_found",   32'(res_if.res_found), 32'd0);
    pix_valid = 1'b1; code_valid = 1'b1; color_code = COL_1;
    repeat (4) @(negedge clk);
    pix_valid = 1'b0; code_valid = 1'b0; color_code = COL_NONE;
    checkOutput("prst_idle_col", 32'(col), 32'd0);
    checkOutput("prst_idle_cnt", 32'(res_if.res_cnt1), 32'd0);

    $display("[TB] recovery frame after reset");
    clearImage();
    fillBlock(2, 2, 9, 9, COL_2);
    fillBlock(0, 12, 1, 4, COL_1);
    applyStimulus(1'b1, H * V);
    collectResult(1);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
